// File: rtl/alu_result_fifo.sv
// alu_result_fifo: a small FIFO that holds ALU results {res, carry, op}
// between the ALU and its consumer. Data flows through a circular buffer
// with a registered head pointer, tail pointer and occupancy count.
// A result offered while the FIFO is full is dropped, and a sticky
// overflow flag records the loss.
// Optional build macro: ALU_RESULT_FIFO_STATS_EN adds carry_cnt, a
// saturating 16-bit count of accepted results whose carry bit is set.

package enums_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } OP_CODE;

  typedef struct packed {
    logic [7:0] res;
    logic       carry;
    OP_CODE     op;
  } res_entry_t;
endpackage

module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_res,
  input  logic                     in_carry,
  input  enums_pkg::OP_CODE        in_op,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out_res,
  output logic                     out_carry,
  output enums_pkg::OP_CODE        out_op,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
`ifdef ALU_RESULT_FIFO_STATS_EN
  output logic [15:0]              carry_cnt,
`endif
  input  logic                     clr_ovf
);
  import enums_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  res_entry_t        r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [AW:0]       r_count;
  logic              r_ovf;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  res_entry_t        w_head;

  // The handshakes depend only on the registered count. Nothing read from
  // storage feeds them, so unknown storage contents never reach the count
  // or the flags.
  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  // A full FIFO does not accept a push, even when a pop happens on the
  // same edge. Data never passes straight from input to output.
  assign w_push   = in_valid & ~w_full;
  assign w_pop    = out_ready & ~w_empty;
  assign w_drop   = in_valid & w_full;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign count     = r_count;
  assign overflow  = r_ovf;

  // The head entry is read straight from storage. Its value does not matter
  // while the FIFO is empty.
  assign w_head    = r_mem[r_head];
  assign out_res   = w_head.res;
  assign out_carry = w_head.carry;
  assign out_op    = w_head.op;

  // Storage write at the tail. There is no reset, because the pointers
  // already decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= '{res: in_res, carry: in_carry, op: in_op};
    end
  end

  // Head and tail pointers. DEPTH is a power of two, so the natural AW-bit
  // wrap gives the modulo-DEPTH behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_ONE;
      if (w_pop)  r_head <= r_head + PTR_ONE;
    end
  end

  // Occupancy count. A push and a pop on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A drop on the same edge as a clear leaves the
  // flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0] r_carry_cnt;

  // Saturating count of accepted results with carry set. It clears
  // together with overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= '0;
    end else if (clr_ovf) begin
      r_carry_cnt <= '0;
    end else if (w_push && in_carry && (r_carry_cnt != 16'hFFFF)) begin
      r_carry_cnt <= r_carry_cnt + 16'd1;
    end
  end

  assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: runs directed scenarios and then random traffic on
// alu_result_fifo (DEPTH=4). A queue-based reference model predicts the
// outputs on every cycle.
module tb_alu_result_fifo;
  import enums_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_res;
  logic              in_carry;
  OP_CODE            in_op;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_res;
  logic              out_carry;
  OP_CODE            out_op;
  logic              out_ready;
  logic [2:0]        count;
  logic              overflow;
  logic              clr_ovf;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0]       carry_cnt;
`endif

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_res    (in_res),
    .in_carry  (in_carry),
    .in_op     (in_op),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_res   (out_res),
    .out_carry (out_carry),
    .out_op    (out_op),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
`ifdef ALU_RESULT_FIFO_STATS_EN
    .carry_cnt (carry_cnt),
`endif
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // reference model state
  res_entry_t  m_q[$];
  bit          m_ovf;
  int unsigned m_cc;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // compare every visible output with the model
  task automatic chk_outs();
    chk("count", 32'(count), 32'(m_q.size()));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("out_res", 32'(out_res), 32'(m_q[0].res));
      chk("out_carry", 32'(out_carry), 32'(m_q[0].carry));
      chk("out_op", 32'(out_op), 32'(m_q[0].op));
    end
`ifdef ALU_RESULT_FIFO_STATS_EN
    chk("carry_cnt", 32'(carry_cnt), m_cc);
`endif
  endtask

  // Drive one cycle. The task checks the outputs before the edge and then
  // moves the model forward by that edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c,
                     input OP_CODE o, input logic rdy, input logic clr);
    bit full, push, pop;
    in_valid = v; in_res = d; in_carry = c; in_op = o;
    out_ready = rdy; clr_ovf = clr;
    chk_outs();
    @(posedge clk);
    full = (m_q.size() == DEPTH);
    push = v && !full;
    pop  = rdy && (m_q.size() != 0);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back('{res: d, carry: c, op: o});
    if (v && full) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    if (clr) m_cc = 0;
    else if (push && c && m_cc != 32'hFFFF) m_cc++;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, OP_ADD, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_q.delete(); m_ovf = 1'b0; m_cc = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 0; in_res = 0; in_carry = 0; in_op = OP_ADD;
    out_ready = 0; clr_ovf = 0;
    #1 rst_n = 1'b0;
    #1;
    m_q.delete(); m_ovf = 1'b0; m_cc = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First push after reset is accepted. It shows up one cycle later.
    cyc(1'b1, 8'h3C, 1'b1, OP_SUB, 1'b0, 1'b0);
    chk("first_res", 32'(out_res), 32'h3C);
    chk("first_carry", 32'(out_carry), 1);
    chk("first_count", 32'(count), 1);
    chk("first_valid", 32'(out_valid), 1);
    cyc(1'b0, 8'h00, 1'b0, OP_ADD, 1'b1, 1'b0);

    // Fill to DEPTH, then drain, checking order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, OP_AND, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(out_res), 32'(i));
      cyc(1'b0, 8'h00, 1'b0, OP_ADD, 1'b1, 1'b0);
    end
    chk("drain_count", 32'(count), 0);

    // Empty pop must not underflow.
    cyc(1'b0, 8'h00, 1'b0, OP_ADD, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(count), 0);

    // Full: a push and a pop on the same edge pop the head and drop the input.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b1, OP_OR, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, OP_XOR, 1'b1, 1'b0);
    chk("full_pp_count", 32'(count), 3);
    chk("full_pp_ovf", 32'(overflow), 1);
    chk("full_pp_head", 32'(out_res), 32'hA1);
    // Overflow is sticky. A drop on the same edge as a clear leaves it set.
    idle();
    cyc(1'b1, 8'h55, 1'b0, OP_ADD, 1'b0, 1'b1); // count 3: accepted, clear
    chk("ovf_cleared", 32'(overflow), 0);
    cyc(1'b1, 8'h66, 1'b0, OP_ADD, 1'b0, 1'b1); // full: drop + clear
    chk("ovf_set_wins", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, OP_ADD, 1'b1, 1'b1);

    // Streaming: count stays at 1 and the pointers wrap.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'(i & 1), OP_CODE'(i % 8), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 1);
    end
    idle(); idle();

    // Asynchronous reset with count=3, in the middle of a cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b0, OP_ADD, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, OP_ADD, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count), 3);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ovf", 32'(overflow), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    m_q.delete(); m_ovf = 1'b0; m_cc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, OP_SHL, 1'b0, 1'b0);
    chk("post_rst_push", 32'(count), 1);
    do_reset();

`ifdef ALU_RESULT_FIFO_STATS_EN
    cyc(1'b1, 8'h01, 1'b1, OP_ADD, 1'b1, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, OP_ADD, 1'b1, 1'b0);
    cyc(1'b1, 8'h03, 1'b1, OP_ADD, 1'b1, 1'b0);
    cyc(1'b1, 8'h04, 1'b1, OP_ADD, 1'b1, 1'b0);
    cyc(1'b1, 8'h05, 1'b0, OP_ADD, 1'b1, 1'b0);
    chk("carry_cnt_3", 32'(carry_cnt), 3);
    cyc(1'b0, 8'h00, 1'b0, OP_ADD, 1'b1, 1'b1);
    chk("carry_cnt_clr", 32'(carry_cnt), 0);
`endif

    // Random traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom),
          OP_CODE'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 5),
          1'($urandom_range(0, 19) == 0));
    end
    chk_outs();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Overall time limit, so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
